axis_packet_accum: RTL and testbench
====================================

Name: axis_packet_accum

Overview:
- Downstream consumer of the 2:1 AXI-stream sample mux.
- Sums the Q2.14 signed samples of each input packet, delimited by tlast, and emits one saturated Q2.14 result beat per packet.
- Also reports the beat count and a saturation flag with each result.
- Both directions use valid/ready handshakes; there is no combinational ready path from the output side to the input side.

Parameters:
- data_width, 16, sample and result width (signed two's complement).
- frac_width, 14, fractional bits; informational only, since the sum is format-preserving.
- int_width, 2, integer bits including sign; data_width = int_width + frac_width.
- acc_width, 24, internal accumulator width; must be >= data_width + 1.
- len_width, 8, width of the beat-count output.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- s_tdata  in  data_width  input sample (Q2.14 signed).
- s_tvalid  in  1  input beat valid.
- s_tlast  in  1  last beat of the input packet.
- s_tready  out  1  block can accept an input beat.
- m_tdata  out  data_width  saturated packet sum (Q2.14 signed).
- m_tvalid  out  1  result beat valid.
- m_tlast  out  1  high whenever m_tvalid is high (each result is a 1-beat packet).
- m_count  out  len_width  beats in the packet, including the last beat.
- m_sat  out  1  result or accumulator was clipped.
- m_tready  in  1  downstream accepts the result.

Behaviour:
- One clock; reset is synchronous and active-low. reset sampled low at a rising edge:
  - state = IDLE, accumulator = 0, internal count = 0, sat = 0.
  - m_tvalid = 0, m_tlast = 0, m_tdata = 0, m_count = 0, m_sat = 0, s_tready = 0.
  - s_tready rises on the first edge with reset high.
- Input accept: s_tvalid && s_tready at a rising edge. Output accept: m_tvalid && m_tready.
- s_tready is a registered output: 1 in IDLE and ACCUM, 0 in OUT.

State machine:
- IDLE: accumulator and count are 0.
  - Accepted beat without tlast: acc = sext(s_tdata), count = 1, go to ACCUM.
  - Accepted beat with tlast: load the result registers (see below), go to OUT.
- ACCUM:
  - Accepted beat without tlast: acc = satacc(acc + sext(s_tdata)), count increments.
  - Accepted beat with tlast: compute final = satacc(acc + sext(s_tdata)), load the result registers, go to OUT.
  - No accepted beat: hold all state.
- OUT: m_tvalid = 1.
  - m_tdata, m_count, m_sat and m_tlast are held stable until the output accept.
  - On output accept: m_tvalid = 0, m_tlast = 0, acc = 0, count = 0, sat = 0, s_tready = 1, go to IDLE. This happens in the same edge.

Latency:
- tlast beat accepted at edge N: m_tvalid = 1 after edge N.
- Result accepted at edge M: s_tready = 1 after edge M.
- Minimum packet period is 1 + L cycles for L beats (one turnaround bubble).

Arithmetic:
- sext() sign-extends data_width to acc_width.
- satacc() clamps to [-2^(acc_width-1), 2^(acc_width-1)-1]; any clamp sets the sticky sat bit.
- Result: final clamped to [-32768, 32767], i.e. 0x8000 / 0x7FFF.
  - m_sat = sticky sat OR output clamp.
  - Otherwise m_tdata = final[data_width-1:0].

Count:
- Includes the tlast beat.
- Saturates at 2^len_width-1 and does not wrap; count saturation does not set m_sat.

Other rules:
- s_tvalid bubbles mid-packet have no effect.
- s_tlast is ignored when no input accept occurs.
- reset low in any state, including mid-packet or while OUT is stalled, discards the partial sum and any pending result.

Test Plan:
- 4 beats of 0x1000 (0.25), last on beat 4, m_tready = 1 → one result 0x4000, m_count = 4, m_sat = 0, m_tlast = 1. m_tvalid is high the cycle after the last accept; s_tready is low for exactly 1 cycle.
- Single beat 0xC000 with s_tlast = 1 → m_tdata = 0xC000, m_count = 1, m_sat = 0; state goes IDLE → OUT directly.
- 3 beats of 0x7000 → m_tdata = 0x7FFF, m_sat = 1. Then 3 beats of 0x8000 → m_tdata = 0x8000, m_sat = 1. Then 2 beats 0x2000, 0xE000 → 0x0000, m_sat = 0, confirming sat clears between packets.
- m_tready held 0 for 6 cycles after a result (sum 0x0800) → m_tvalid, m_tdata, m_count held; s_tready = 0. The next packet's first beat, held valid throughout, is accepted on the edge after m_tready rises.
- Random s_tvalid gaps within a 5-beat packet 0x0100 × 5 → m_tdata = 0x0500, m_count = 5.
- reset low for 1 cycle after 2 accepted beats of 0x3000 → all outputs 0. Then a fresh packet 0x0400, 0x0400 (last) → m_tdata = 0x0800, m_count = 2.

Source files
------------

// File: rtl/axis_packet_accum.sv
// axis_packet_accum: sums the Q2.14 samples of each tlast-delimited input
// packet and emits one saturated Q2.14 result beat per packet, together with
// the packet's beat count and a saturation flag.
module axis_packet_accum #(
  parameter int unsigned data_width = 16,
  parameter int unsigned frac_width = 14,
  parameter int unsigned int_width  = 2,
  parameter int unsigned acc_width  = 24,
  parameter int unsigned len_width  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [data_width-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic [len_width-1:0]  m_count,
  output logic                  m_sat,
  input  logic                  m_tready
);

  if ((int_width + frac_width != data_width) || (acc_width < data_width + 1)) begin : g_bad_params
    $error("axis_packet_accum: inconsistent width parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_t;

  localparam logic [acc_width-1:0]  ACC_MAX = {1'b0, {(acc_width-1){1'b1}}};
  localparam logic [acc_width-1:0]  ACC_MIN = {1'b1, {(acc_width-1){1'b0}}};
  localparam logic [data_width-1:0] OUT_MAX = {1'b0, {(data_width-1){1'b1}}};
  localparam logic [data_width-1:0] OUT_MIN = {1'b1, {(data_width-1){1'b0}}};

  state_t                state_q, state_d;
  logic [acc_width-1:0]  acc_q, acc_d;
  logic [len_width-1:0]  cnt_q, cnt_d;
  logic                  sat_q, sat_d;
  logic                  s_tready_q, s_tready_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [data_width-1:0] m_tdata_q, m_tdata_d;
  logic [len_width-1:0]  m_count_q, m_count_d;
  logic                  m_sat_q, m_sat_d;

  logic [acc_width:0]    sum_w;
  logic [acc_width-1:0]  acc_next;
  logic                  acc_clip;
  logic                  out_clip;
  logic [data_width-1:0] out_val;
  logic [len_width-1:0]  cnt_inc;
  logic                  in_acc;
  logic                  out_acc;

  assign in_acc  = s_tvalid && s_tready_q;
  assign out_acc = m_tvalid_q && m_tready;

  // Running sum with accumulator clamp, output clamp and saturating count.
  always_comb begin
    sum_w    = {acc_q[acc_width-1], acc_q}
             + {{(acc_width+1-data_width){s_tdata[data_width-1]}}, s_tdata};
    acc_clip = sum_w[acc_width] ^ sum_w[acc_width-1];
    if (!acc_clip) begin
      acc_next = sum_w[acc_width-1:0];
    end else if (sum_w[acc_width]) begin
      acc_next = ACC_MIN;
    end else begin
      acc_next = ACC_MAX;
    end
    out_clip = !((&acc_next[acc_width-1:data_width-1]) || !(|acc_next[acc_width-1:data_width-1]));
    if (!out_clip) begin
      out_val = acc_next[data_width-1:0];
    end else if (acc_next[acc_width-1]) begin
      out_val = OUT_MIN;
    end else begin
      out_val = OUT_MAX;
    end
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + len_width'(1);
  end

  // Next-state and registered-output logic; IDLE holds acc/count at zero, so
  // the first beat uses the same add path as later beats.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    m_count_d  = m_count_q;
    m_sat_d    = m_sat_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (in_acc) begin
          if (s_tlast) begin
            m_tvalid_d = 1'b1;
            m_tlast_d  = 1'b1;
            m_tdata_d  = out_val;
            m_count_d  = cnt_inc;
            m_sat_d    = sat_q || acc_clip || out_clip;
            state_d    = OUT;
          end else begin
            acc_d   = acc_next;
            cnt_d   = cnt_inc;
            sat_d   = sat_q || acc_clip;
            state_d = ACCUM;
          end
        end
      end
      OUT: begin
        if (out_acc) begin
          m_tvalid_d = 1'b0;
          m_tlast_d  = 1'b0;
          acc_d      = '0;
          cnt_d      = '0;
          sat_d      = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    s_tready_d = (state_d != OUT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      m_count_q  <= '0;
      m_sat_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
      m_count_q  <= m_count_d;
      m_sat_q    <= m_sat_d;
    end
  end

  assign s_tready = s_tready_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tdata  = m_tdata_q;
  assign m_count  = m_count_q;
  assign m_sat    = m_sat_q;

endmodule

// File: tb/tb_axis_packet_accum.sv
// Bench for axis_packet_accum: directed and random packets checked against a
// plain-arithmetic reference of the packet sum, count and saturation rules.
module tb_axis_packet_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic [7:0]  m_count;
  logic        m_sat;
  logic        m_tready;

  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [15:0] pkt[$];

  axis_packet_accum #(
    .data_width(16),
    .frac_width(14),
    .int_width (2),
    .acc_width (24),
    .len_width (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_tdata (s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast (s_tlast),
    .s_tready(s_tready),
    .m_tdata (m_tdata),
    .m_tvalid(m_tvalid),
    .m_tlast (m_tlast),
    .m_count (m_count),
    .m_sat   (m_sat),
    .m_tready(m_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: saturating running sum at 24 bits, then clip to 16 bits.
  task automatic model(input logic [15:0] s[$], output logic [15:0] d,
                       output logic [7:0] c, output logic sat);
    longint acc;
    acc = 0;
    sat = 1'b0;
    foreach (s[i]) begin
      acc += longint'($signed(s[i]));
      if (acc > 64'sd8388607) begin
        acc = 8388607;
        sat = 1'b1;
      end else if (acc < -64'sd8388608) begin
        acc = -8388608;
        sat = 1'b1;
      end
    end
    if (acc > 64'sd32767) begin
      d   = 16'h7FFF;
      sat = 1'b1;
    end else if (acc < -64'sd32768) begin
      d   = 16'h8000;
      sat = 1'b1;
    end else begin
      d = 16'(acc);
    end
    c = (s.size() > 255) ? 8'hFF : 8'(s.size());
  endtask

  // Entered at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!s_tready && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!s_tready) chk("beat_timeout", 32'(s_tready), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_pkt(input int unsigned max_gap);
    for (int i = 0; i < pkt.size(); i++) begin
      int unsigned gaps;
      gaps = (max_gap != 0) ? $urandom_range(max_gap, 0) : 0;
      repeat (gaps) begin
        s_tvalid = 1'b0;
        s_tlast  = 1'($urandom);
        s_tdata  = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
      end
      send_beat(pkt[i], (i == pkt.size() - 1));
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Called at the negedge right after the tlast accept.
  task automatic check_result(input string tag, input int unsigned stall);
    logic [15:0] ed;
    logic [7:0]  ec;
    logic        es;
    model(pkt, ed, ec, es);
    chk({tag, "_valid"}, 32'(m_tvalid), 32'd1);
    chk({tag, "_data"}, 32'(m_tdata), 32'(ed));
    chk({tag, "_count"}, 32'(m_count), 32'(ec));
    chk({tag, "_sat"}, 32'(m_sat), 32'(es));
    chk({tag, "_tlast"}, 32'(m_tlast), 32'd1);
    chk({tag, "_sready_lo"}, 32'(s_tready), 32'd0);
    m_tready = 1'b0;
    repeat (stall) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(m_tvalid), 32'd1);
      chk({tag, "_hold_data"}, 32'(m_tdata), 32'(ed));
      chk({tag, "_hold_count"}, 32'(m_count), 32'(ec));
      chk({tag, "_hold_sready"}, 32'(s_tready), 32'd0);
    end
    m_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_tready = 1'b0;
    chk({tag, "_valid_clr"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_tlast_clr"}, 32'(m_tlast), 32'd0);
    chk({tag, "_sready_hi"}, 32'(s_tready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sready"}, 32'(s_tready), 32'd0);
    chk({tag, "_mvalid"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_mlast"}, 32'(m_tlast), 32'd0);
    chk({tag, "_mdata"}, 32'(m_tdata), 32'd0);
    chk({tag, "_mcount"}, 32'(m_count), 32'd0);
    chk({tag, "_msat"}, 32'(m_sat), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("por_sready_rise", 32'(s_tready), 32'd1);

    pkt = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    send_pkt(0);
    check_result("quarter4", 0);

    pkt = '{16'hC000};
    send_pkt(0);
    check_result("single", 0);

    pkt = '{16'h7000, 16'h7000, 16'h7000};
    send_pkt(0);
    check_result("pos_clip", 0);
    pkt = '{16'h8000, 16'h8000, 16'h8000};
    send_pkt(0);
    check_result("neg_clip", 0);
    pkt = '{16'h2000, 16'hE000};
    send_pkt(0);
    check_result("sat_clear", 0);

    // Stalled result with the next packet's first beat already waiting.
    pkt = '{16'h0800};
    send_pkt(0);
    s_tdata  = 16'h0100;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    check_result("stall", 6);
    @(posedge clk);
    @(negedge clk);
    pkt = '{16'h0100, 16'h0100};
    send_beat(16'h0100, 1'b1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check_result("after_stall", 0);

    pkt = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    send_pkt(3);
    check_result("gaps", 0);

    // Reset mid-packet discards the partial sum.
    send_beat(16'h3000, 1'b0);
    send_beat(16'h3000, 1'b0);
    s_tvalid = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("mid_rst");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_sready", 32'(s_tready), 32'd1);
    pkt = '{16'h0400, 16'h0400};
    send_pkt(0);
    check_result("post_rst", 0);

    // Reset while a result is pending.
    pkt = '{16'h1234};
    send_pkt(0);
    chk("pend_valid", 32'(m_tvalid), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("pend_rst");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Long packets: accumulator clamp and count saturation.
    pkt.delete();
    repeat (300) pkt.push_back(16'h7FFF);
    send_pkt(0);
    check_result("long_pos", 0);
    pkt.delete();
    repeat (300) pkt.push_back(16'h8000);
    send_pkt(0);
    check_result("long_neg", 0);

    for (int p = 0; p < 20; p++) begin
      int unsigned len;
      len = $urandom_range(12, 1);
      pkt.delete();
      repeat (len) pkt.push_back(16'($urandom));
      send_pkt(2);
      check_result($sformatf("rnd%0d", p), $urandom_range(2, 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
